mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single main-memory port between I-cache and D-cache for the 16-bit pipelined CPU.
- Performs 8-word block fills on cache misses and single-word write-through stores.
- Produces the stall signals that drive the enable inputs of the pipeline stage flops (F/D, D/X, X/M, M/W).
- Main memory is pipelined: accepts one request per cycle and returns read data MEM_LATENCY cycles later with mem_data_valid.

Parameters:
- WORDS_PER_BLOCK, 8, words per cache block; power of two; fill length.
- MEM_LATENCY, 4, cycles from read issue to mem_data_valid; informational only, the block counts mem_data_valid pulses.
- ADDR_W, 16, byte-address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low
- icache_miss  in  1  I-cache miss request, level, held until icache_fill_done
- icache_addr  in  16  byte address of missing instruction
- dcache_miss  in  1  D-cache miss request, level, held until dcache_fill_done
- dcache_addr  in  16  byte address of missing data / store address
- dcache_wr_req  in  1  write-through store request, level, held until dcache_wr_done
- dcache_wdata  in  16  store data
- mem_en  out  1  memory request valid this cycle
- mem_wr  out  1  1 = write, 0 = read
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_data_valid  in  1  read data valid from memory
- fill_word_idx  out  log2(WORDS_PER_BLOCK)  word index of current returning fill word
- icache_fill_we  out  1  write the returning word into the I-cache block
- dcache_fill_we  out  1  write the returning word into the D-cache block
- icache_fill_done  out  1  one-cycle pulse, I fill complete
- dcache_fill_done  out  1  one-cycle pulse, D fill complete
- dcache_wr_done  out  1  one-cycle pulse, store issued
- stall_fetch  out  1  freeze PC and F/D flops
- stall_mem  out  1  freeze all stage flops through M/W; insert no bubble

Behaviour:
- States: IDLE, IFILL, DFILL, DWRITE. Registered state, issue counter (iss_cnt), receive counter (rcv_cnt).
- Reset (rst=0, asynchronous): state IDLE, both counters 0, latched base address 0. All outputs 0 except mem_addr=0 and mem_wdata=0.
- IDLE arbitration, evaluated each cycle. Priority: dcache_miss, then dcache_wr_req, then icache_miss. The D side holds the older instruction.
- On entry to IFILL/DFILL: latch base = addr with low 4 bits cleared; clear both counters.
- Issue phase in IFILL/DFILL:
  - While iss_cnt < WORDS_PER_BLOCK: mem_en=1, mem_wr=0, mem_addr = base + 2*iss_cnt, iss_cnt++.
  - After that, mem_en=0.
  - First request is issued in the cycle after the grant.
- Receive phase:
  - Each mem_data_valid asserts the active fill_we and sets fill_word_idx=rcv_cnt; rcv_cnt++.
  - On the valid with rcv_cnt = WORDS_PER_BLOCK-1: pulse the matching fill_done that same cycle, then next state is IDLE.
  - mem_data_valid while in IDLE or DWRITE is ignored.
- DWRITE: lasts exactly one cycle.
  - Outputs mem_en=1, mem_wr=1, mem_addr=dcache_addr, mem_wdata=dcache_wdata, dcache_wr_done=1.
  - Returns to IDLE.
- Store miss (dcache_miss and dcache_wr_req both high): DFILL first. From DFILL completion go directly to DWRITE if dcache_wr_req is still high, bypassing arbitration.
- Stall outputs (combinational from state and requests):
  - stall_mem = dcache_miss | dcache_wr_req | (state==DFILL) | (state==DWRITE).
  - stall_fetch = stall_mem | icache_miss | (state==IFILL).
  - A pending I-miss stalls only fetch while the D side is idle.
- Grant is non-preemptive. A request that arrives during another fill waits in IDLE for arbitration.
- A request deasserted mid-fill is ignored; the fill completes and the done pulse is still produced.
- Nominal fill latency: 1 grant cycle + 8 issue cycles, with the last data arriving MEM_LATENCY cycles after the last issue. Total 12 cycles from grant to fill_done at defaults.
- Address arithmetic is mod 2^16. Base + 14 never crosses a block boundary.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: 1-bit last_grant register, reset 0.
  - When dcache_miss and icache_miss are both pending in IDLE, grant the side not served last.
  - dcache_wr_req keeps priority over icache_miss.
  - last_grant updates at every fill grant.
- Undefined: fixed D-over-I priority as above; no extra register.

Test Plan:
- I-miss alone: icache_addr=0x1236 → reads issued to 0x1230,0x1232,…,0x123E on 8 consecutive cycles; 8 icache_fill_we with idx 0..7; icache_fill_done 12 cycles after grant; stall_fetch=1 throughout, stall_mem=0.
- Simultaneous I and D miss: dcache_addr=0x4008, icache_addr=0x0100 → DFILL at 0x4000 runs first with stall_mem=1; IFILL at 0x0100 follows; with ARB_ROUND_ROBIN_EN and last_grant=D, IFILL runs first instead.
- Store hit: dcache_wr_req=1, addr=0x2002, wdata=0xBEEF → one cycle mem_en=1, mem_wr=1, mem_addr=0x2002, mem_wdata=0xBEEF, dcache_wr_done=1; back to IDLE.
- Store miss: dcache_miss and dcache_wr_req with addr=0x3004 → DFILL at 0x3000; DWRITE immediately after dcache_fill_done; stall_mem held until the write cycle ends.
- Reset mid-fill: rst=0 after 3 words received → all outputs 0 immediately; after release, a new icache_miss restarts at word 0 and late mem_data_valid pulses received in IDLE cause no fill_we.
- Request dropped mid-fill: icache_miss deasserted at word 2 → all 8 words still written and icache_fill_done still pulses.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single pipelined main-memory port between the I-cache and the
// D-cache of the 16-bit CPU. It performs WORDS_PER_BLOCK-word block fills on
// cache misses and single-word write-through stores. It also produces the
// stall signals that gate the pipeline stage flops.
//
// Optional feature, enabled by defining ARB_ROUND_ROBIN_EN:
//   When dcache_miss and icache_miss are pending together, the arbiter
//   alternates between the two sides instead of always serving D first.
//   Without the macro, D-side requests always win and no extra state exists.

module mem_arbiter #(
  parameter  int WORDS_PER_BLOCK = 8,
  parameter  int MEM_LATENCY     = 4,
  parameter  int ADDR_W          = 16,
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_miss,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_miss,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              dcache_wr_req,
  input  logic [15:0]       dcache_wdata,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_data_valid,
  output logic [IDX_W-1:0]  fill_word_idx,
  output logic              icache_fill_we,
  output logic              dcache_fill_we,
  output logic              icache_fill_done,
  output logic              dcache_fill_done,
  output logic              dcache_wr_done,
  output logic              stall_fetch,
  output logic              stall_mem
);

  // The issue counter needs one extra bit so that it can reach
  // WORDS_PER_BLOCK, which marks the end of the issue phase.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  // Reject configurations the counters and masks cannot represent.
  if ((WORDS_PER_BLOCK < 2) || ((WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) ||
      (MEM_LATENCY < 1)) begin : g_bad_param
    $error("mem_arbiter: WORDS_PER_BLOCK must be a power of two >= 2 and MEM_LATENCY >= 1");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IFILL  = 2'd1,
    DFILL  = 2'd2,
    DWRITE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   iss_cnt_q;
  logic [IDX_W-1:0]   rcv_cnt_q;
  logic [ADDR_W-1:0]  base_q;

  logic               start_fill;   // a fill is granted this cycle
  logic               start_sel_d;  // the granted fill belongs to the D side
  logic               filling;
  logic               issuing;
  logic               rx_word;
  logic               last_word;
  logic               stall_mem_raw;

`ifdef ARB_ROUND_ROBIN_EN
  logic               last_grant_q; // 1: the most recent fill grant went to D
`endif

  // Request arbitration in IDLE and fill or store sequencing in the other states.
  always_comb begin
    // NOTE: every variable gets a default first so that no path through the
    // case statement leaves it unassigned, which would infer a latch.
    state_d     = state_q;
    start_fill  = 1'b0;
    start_sel_d = 1'b0;
    unique case (state_q)
      IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
        if (dcache_miss && icache_miss) begin
          start_fill  = 1'b1;
          start_sel_d = ~last_grant_q;
          state_d     = last_grant_q ? IFILL : DFILL;
        end else
`endif
        if (dcache_miss) begin
          start_fill  = 1'b1;
          start_sel_d = 1'b1;
          state_d     = DFILL;
        end else if (dcache_wr_req) begin
          state_d     = DWRITE;
        end else if (icache_miss) begin
          start_fill  = 1'b1;
          start_sel_d = 1'b0;
          state_d     = IFILL;
        end
      end
      IFILL: begin
        if (last_word) state_d = IDLE;
      end
      DFILL: begin
        // A store miss goes straight to its write once the block is in place.
        if (last_word) state_d = dcache_wr_req ? DWRITE : IDLE;
      end
      DWRITE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // flop samples values from before the clock edge.
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Block base address and the issue and receive counters of the active fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q    <= '0;
      iss_cnt_q <= '0;
      rcv_cnt_q <= '0;
    end else if (start_fill) begin
      base_q    <= (start_sel_d ? dcache_addr : icache_addr) & ~BLK_MASK;
      iss_cnt_q <= '0;
      rcv_cnt_q <= '0;
    end else if (filling) begin
      if (issuing)        iss_cnt_q <= iss_cnt_q + 1'b1;
      if (mem_data_valid) rcv_cnt_q <= rcv_cnt_q + 1'b1;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which side received the last fill grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            last_grant_q <= 1'b0;
    else if (start_fill) last_grant_q <= start_sel_d;
  end
`endif

  // Memory-port, cache-fill and handshake outputs.
  always_comb begin
    filling   = (state_q == IFILL) || (state_q == DFILL);
    issuing   = filling && (iss_cnt_q < CNT_W'(WORDS_PER_BLOCK));
    rx_word   = filling && mem_data_valid;
    last_word = rx_word && (rcv_cnt_q == IDX_W'(WORDS_PER_BLOCK - 1));

    mem_en    = issuing || (state_q == DWRITE);
    mem_wr    = (state_q == DWRITE);
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == DWRITE) begin
      mem_addr  = dcache_addr;
      mem_wdata = dcache_wdata;
    end else if (issuing) begin
      mem_addr  = base_q + ADDR_W'({iss_cnt_q[IDX_W-1:0], 1'b0});
    end

    fill_word_idx    = rx_word ? rcv_cnt_q : '0;
    icache_fill_we   = rx_word && (state_q == IFILL);
    dcache_fill_we   = rx_word && (state_q == DFILL);
    icache_fill_done = last_word && (state_q == IFILL);
    dcache_fill_done = last_word && (state_q == DFILL);
    dcache_wr_done   = (state_q == DWRITE);
  end

  // Pipeline stalls. A pending I-miss freezes only fetch while the D side is
  // quiet. Both stalls are forced low while reset is asserted so that every
  // output starts from zero.
  always_comb begin
    stall_mem_raw = dcache_miss || dcache_wr_req ||
                    (state_q == DFILL) || (state_q == DWRITE);
    stall_mem     = rst && stall_mem_raw;
    stall_fetch   = rst && (stall_mem_raw || icache_miss || (state_q == IFILL));
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Directed and randomized stimulus for mem_arbiter. A pipelined memory with a
// fixed read latency answers the read requests. Expected outputs come from a
// timeline model: a fill granted at relative cycle 0 issues word i at cycle
// 1+i, sees it return at cycle 1+i+LAT and completes at cycle WORDS+LAT.

module tb_mem_arbiter;

  localparam int W   = 8;
  localparam int LAT = 4;

  typedef struct packed {
    logic        en;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        i_we;
    logic        d_we;
    logic [2:0]  idx;
    logic        i_done;
    logic        d_done;
    logic        wr_done;
    logic        s_mem;
    logic        s_fetch;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        icache_miss;
  logic [15:0] icache_addr;
  logic        dcache_miss;
  logic [15:0] dcache_addr;
  logic        dcache_wr_req;
  logic [15:0] dcache_wdata;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_data_valid;
  logic [2:0]  fill_word_idx;
  logic        icache_fill_we;
  logic        dcache_fill_we;
  logic        icache_fill_done;
  logic        dcache_fill_done;
  logic        dcache_wr_done;
  logic        stall_fetch;
  logic        stall_mem;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(
    .WORDS_PER_BLOCK(W),
    .MEM_LATENCY    (LAT),
    .ADDR_W         (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .icache_miss     (icache_miss),
    .icache_addr     (icache_addr),
    .dcache_miss     (dcache_miss),
    .dcache_addr     (dcache_addr),
    .dcache_wr_req   (dcache_wr_req),
    .dcache_wdata    (dcache_wdata),
    .mem_en          (mem_en),
    .mem_wr          (mem_wr),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_data_valid  (mem_data_valid),
    .fill_word_idx   (fill_word_idx),
    .icache_fill_we  (icache_fill_we),
    .dcache_fill_we  (dcache_fill_we),
    .icache_fill_done(icache_fill_done),
    .dcache_fill_done(dcache_fill_done),
    .dcache_wr_done  (dcache_wr_done),
    .stall_fetch     (stall_fetch),
    .stall_mem       (stall_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pipelined memory: a read accepted in cycle k returns mem_data_valid in
  // cycle k+LAT. It keeps running through reset, as real memory would.
  logic [LAT-2:0] pipe = '0;
  initial mem_data_valid = 1'b0;
  always @(posedge clk) begin
    mem_data_valid <= pipe[LAT-2];
    pipe           <= {pipe[LAT-3:0], mem_en & ~mem_wr};
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare every output with e. Address, data and index are compared only
  // when they are meaningful, or always when strict is set.
  task automatic check_all(input string tag, input exp_t e, input bit strict);
    chk({tag, " mem_en"}, 16'(mem_en), 16'(e.en));
    chk({tag, " mem_wr"}, 16'(mem_wr), 16'(e.wr));
    if (strict || e.en) chk({tag, " mem_addr"}, mem_addr, e.addr);
    if (strict || e.wr) chk({tag, " mem_wdata"}, mem_wdata, e.wdata);
    chk({tag, " icache_fill_we"}, 16'(icache_fill_we), 16'(e.i_we));
    chk({tag, " dcache_fill_we"}, 16'(dcache_fill_we), 16'(e.d_we));
    if (strict || e.i_we || e.d_we) chk({tag, " fill_word_idx"}, 16'(fill_word_idx), 16'(e.idx));
    chk({tag, " icache_fill_done"}, 16'(icache_fill_done), 16'(e.i_done));
    chk({tag, " dcache_fill_done"}, 16'(dcache_fill_done), 16'(e.d_done));
    chk({tag, " dcache_wr_done"}, 16'(dcache_wr_done), 16'(e.wr_done));
    chk({tag, " stall_mem"}, 16'(stall_mem), 16'(e.s_mem));
    chk({tag, " stall_fetch"}, 16'(stall_fetch), 16'(e.s_fetch));
  endtask

  // Move to the next cycle; inputs change just after the rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // One cycle with no requests: every output must be quiet.
  task automatic idle_cycle(input string tag);
    exp_t e;
    next_cycle();
    icache_miss   = 1'b0;
    dcache_miss   = 1'b0;
    dcache_wr_req = 1'b0;
    @(negedge clk);
    e = '0;
    check_all(tag, e, 1'b0);
  endtask

  // A complete fill. Relative cycle 0 is the grant cycle. drop_at < 0 keeps
  // the miss asserted. For a D fill, co_i also raises an I-miss in the grant
  // cycle, and store adds the write-through that follows the fill.
  task automatic run_fill(input string name, input bit is_d, input logic [15:0] addr,
                          input bit store, input logic [15:0] wdata, input int drop_at,
                          input bit co_i, input logic [15:0] co_i_addr);
    logic [15:0] base;
    exp_t        e;
    bit          rx;
    base = addr & 16'hFFF0;
    for (int t = 0; t <= W + LAT; t++) begin
      next_cycle();
      if (t == 0) begin
        if (is_d) begin
          dcache_miss   = 1'b1;
          dcache_addr   = addr;
          dcache_wr_req = store;
          dcache_wdata  = wdata;
          if (co_i) begin
            icache_miss = 1'b1;
            icache_addr = co_i_addr;
          end
        end else begin
          dcache_miss   = 1'b0;
          dcache_wr_req = 1'b0;
          icache_miss   = 1'b1;
          icache_addr   = addr;
        end
      end
      if (t == drop_at) begin
        if (is_d) dcache_miss = 1'b0;
        else      icache_miss = 1'b0;
      end
      @(negedge clk);
      e         = '0;
      rx        = (t >= 1 + LAT) && (t <= W + LAT);
      e.en      = (t >= 1) && (t <= W);
      e.addr    = base + 16'(2 * (t - 1));
      e.i_we    = rx && !is_d;
      e.d_we    = rx && is_d;
      e.idx     = 3'(t - 1 - LAT);
      e.i_done  = (t == W + LAT) && !is_d;
      e.d_done  = (t == W + LAT) && is_d;
      e.s_mem   = is_d;
      e.s_fetch = 1'b1;
      check_all($sformatf("%s t%0d", name, t), e, 1'b0);
    end
    if (store) begin
      next_cycle();
      dcache_miss = 1'b0;
      @(negedge clk);
      e         = '0;
      e.en      = 1'b1;
      e.wr      = 1'b1;
      e.addr    = addr;
      e.wdata   = wdata;
      e.wr_done = 1'b1;
      e.s_mem   = 1'b1;
      e.s_fetch = 1'b1;
      check_all({name, " write"}, e, 1'b0);
    end
  endtask

  // A store that hits: one arbitration cycle followed by one write cycle.
  task automatic store_hit(input string name, input logic [15:0] addr, input logic [15:0] wdata);
    exp_t e;
    next_cycle();
    dcache_wr_req = 1'b1;
    dcache_addr   = addr;
    dcache_wdata  = wdata;
    @(negedge clk);
    e         = '0;
    e.s_mem   = 1'b1;
    e.s_fetch = 1'b1;
    check_all({name, " grant"}, e, 1'b0);
    next_cycle();
    @(negedge clk);
    e.en      = 1'b1;
    e.wr      = 1'b1;
    e.addr    = addr;
    e.wdata   = wdata;
    e.wr_done = 1'b1;
    check_all({name, " write"}, e, 1'b0);
  endtask

  // Safety net in case the run stops advancing.
  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    int   kind;
    int   drop;

    rst           = 1'b0;
    icache_miss   = 1'b1;
    icache_addr   = 16'h5555;
    dcache_miss   = 1'b0;
    dcache_addr   = 16'h0000;
    dcache_wr_req = 1'b1;
    dcache_wdata  = 16'h1234;

    // Reset: every output is zero, even with requests present.
    repeat (2) next_cycle();
    @(negedge clk);
    e = '0;
    check_all("reset", e, 1'b1);
    next_cycle();
    icache_miss   = 1'b0;
    dcache_wr_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    idle_cycle("post-reset idle");

    // I-miss alone.
    run_fill("imiss", 1'b0, 16'h1236, 1'b0, 16'h0, -1, 1'b0, 16'h0);
    idle_cycle("imiss idle");

    // I-miss and D-miss together: D is served first, then I.
    run_fill("both d", 1'b1, 16'h4008, 1'b0, 16'h0, -1, 1'b1, 16'h0100);
    run_fill("both i", 1'b0, 16'h0100, 1'b0, 16'h0, -1, 1'b0, 16'h0);
    idle_cycle("both idle");

    // Store hit.
    store_hit("store hit", 16'h2002, 16'hBEEF);
    idle_cycle("store hit idle");

    // Store miss: D fill followed directly by the write.
    run_fill("store miss", 1'b1, 16'h3004, 1'b1, 16'hCAFE, -1, 1'b0, 16'h0);
    idle_cycle("store miss idle");

    // Reset after three fill words have returned.
    next_cycle();
    icache_miss = 1'b1;
    icache_addr = 16'h7A10;
    for (int t = 1; t <= 7; t++) next_cycle();
    @(negedge clk);
    chk("pre-reset third word idx", 16'(fill_word_idx), 16'd2);
    chk("pre-reset third word we", 16'(icache_fill_we), 16'd1);
    next_cycle();
    rst = 1'b0;
    #1;
    e = '0;
    check_all("reset mid-fill", e, 1'b1);
    icache_miss = 1'b0;
    next_cycle();
    @(negedge clk);
    check_all("reset mid-fill held", e, 1'b1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check_all("reset release", e, 1'b0);
    // Late returns from the aborted fill arrive here and must be ignored.
    for (int i = 0; i < 3; i++) idle_cycle($sformatf("late return %0d", i));
    run_fill("after reset", 1'b0, 16'h7A10, 1'b0, 16'h0, -1, 1'b0, 16'h0);
    idle_cycle("after reset idle");

    // I-miss dropped when word 2 returns: the fill still completes.
    run_fill("drop", 1'b0, 16'h0C46, 1'b0, 16'h0, 1 + LAT + 2, 1'b0, 16'h0);
    idle_cycle("drop idle");

    // Randomized traffic.
    for (int n = 0; n < 24; n++) begin
      kind = int'($urandom_range(0, 4));
      drop = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, W + LAT - 1)) : -1;
      case (kind)
        0: run_fill($sformatf("rnd%0d ifill", n), 1'b0, 16'($urandom), 1'b0, 16'h0,
                    drop, 1'b0, 16'h0);
        1: run_fill($sformatf("rnd%0d dfill", n), 1'b1, 16'($urandom), 1'b0, 16'h0,
                    drop, 1'b0, 16'h0);
        2: store_hit($sformatf("rnd%0d store", n), 16'($urandom), 16'($urandom));
        3: run_fill($sformatf("rnd%0d smiss", n), 1'b1, 16'($urandom), 1'b1,
                    16'($urandom), drop, 1'b0, 16'h0);
        default: begin
          logic [15:0] ia;
          ia = 16'($urandom);
          run_fill($sformatf("rnd%0d both d", n), 1'b1, 16'($urandom), 1'b0, 16'h0,
                   drop, 1'b1, ia);
          run_fill($sformatf("rnd%0d both i", n), 1'b0, ia, 1'b0, 16'h0, -1, 1'b0, 16'h0);
        end
      endcase
      idle_cycle($sformatf("rnd%0d idle", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
